// File: rtl/core_id_fifo_queue.sv
// FIFO of core IDs with ready/valid handshake, occupancy count and per-core duplicate suppression.
// Optional CORE_QUEUE_EDGE_TRIGGER_EN: enqueue_valid/current_consume act on rising edges only.
module core_id_fifo_queue #(
  parameter int CORES = 4,
  parameter int DEPTH = 4,
  localparam int IDW = (CORES > 1) ? $clog2(CORES) : 1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IDW-1:0] enqueue_id,
  input  logic           enqueue_valid,
  output logic           enqueue_ready,
  output logic [IDW-1:0] current_id,
  output logic           current_valid,
  input  logic           current_consume,
  output logic [CW-1:0]  count,
  output logic           dup_drop,
  output logic           overflow
);

  localparam int NID = 1 << IDW;
  // IDs at or above CORES have no core behind them; they always read as pending so they get dropped.
  localparam logic [NID-1:0] OOR_MASK = ~((NID'(1) << CORES) - NID'(1));
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [IDW-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [NID-1:0] pending;

  logic           enq_req;
  logic           deq_req;
  logic           enq;
  logic           deq;
  logic           dup;
  logic           ovf_set;
  logic [IDW-1:0] head_id;
  logic [NID-1:0] head_clr;
  logic [NID-1:0] pending_eff;
  logic [NID-1:0] pending_nxt;

`ifdef CORE_QUEUE_EDGE_TRIGGER_EN
  logic enqueue_valid_d;
  logic current_consume_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enqueue_valid_d   <= 1'b0;
      current_consume_d <= 1'b0;
    end else begin
      enqueue_valid_d   <= enqueue_valid;
      current_consume_d <= current_consume;
    end
  end

  assign enq_req = enqueue_valid & ~enqueue_valid_d;
  assign deq_req = current_consume & ~current_consume_d;
`else
  assign enq_req = enqueue_valid;
  assign deq_req = current_consume;
`endif

  assign enqueue_ready = (count != FULL_CNT);
  assign current_valid = (count != '0);
  assign head_id       = mem[rd_ptr];
  assign current_id    = current_valid ? head_id : '0;

  // The popped head's bit is released this cycle so its core may re-enqueue immediately.
  always_comb begin
    head_clr = '0;
    if (deq) head_clr = NID'(1) << head_id;
    pending_eff = (pending | OOR_MASK) & ~head_clr;
    pending_nxt = pending & ~head_clr;
    if (enq) pending_nxt = pending_nxt | (NID'(1) << enqueue_id);
  end

  assign deq     = deq_req & current_valid;
  assign dup     = enq_req & enqueue_ready & pending_eff[enqueue_id];
  assign enq     = enq_req & enqueue_ready & ~pending_eff[enqueue_id];
  assign ovf_set = enq_req & ~enqueue_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pending  <= '0;
      dup_drop <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count    <= count + CW'(enq) - CW'(deq);
      pending  <= pending_nxt;
      dup_drop <= dup;
      overflow <= overflow | ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= enqueue_id;
  end

endmodule

// File: tb/tb_core_id_fifo_queue.sv
// Directed checks of core_id_fifo_queue (CORES=4, DEPTH=4).
module tb_core_id_fifo_queue;

  logic       clk;
  logic       reset;
  logic [1:0] enqueue_id;
  logic       enqueue_valid;
  logic       enqueue_ready;
  logic [1:0] current_id;
  logic       current_valid;
  logic       current_consume;
  logic [2:0] count;
  logic       dup_drop;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  core_id_fifo_queue #(.CORES(4), .DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .enqueue_id(enqueue_id),
    .enqueue_valid(enqueue_valid),
    .enqueue_ready(enqueue_ready),
    .current_id(current_id),
    .current_valid(current_valid),
    .current_consume(current_consume),
    .count(count),
    .dup_drop(dup_drop),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enqueue_valid   = 1'b0;
    current_consume = 1'b0;
  endtask

`ifndef CORE_QUEUE_EDGE_TRIGGER_EN
  int fill_ids [4] = '{2, 0, 3, 1};
`endif

  initial begin
    reset = 1'b1;
    enqueue_id = '0;
    idle();
    #2;
    check_val("rst_count", int'(count), 0);
    check_val("rst_valid", int'(current_valid), 0);
    check_val("rst_ready", int'(enqueue_ready), 1);
    check_val("rst_id", int'(current_id), 0);
    check_val("rst_dup", int'(dup_drop), 0);
    check_val("rst_ovf", int'(overflow), 0);
    step();
    reset = 1'b0;

`ifndef CORE_QUEUE_EDGE_TRIGGER_EN
    // Fill in order, then drain in order.
    for (int i = 0; i < 4; i++) begin
      enqueue_valid = 1'b1;
      enqueue_id = 2'(fill_ids[i]);
      step();
      check_val("fill_count", int'(count), i + 1);
    end
    idle();
    check_val("full_ready", int'(enqueue_ready), 0);
    check_val("full_valid", int'(current_valid), 1);
    current_consume = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("pop_id", int'(current_id), fill_ids[i]);
      step();
    end
    idle();
    check_val("drain_valid", int'(current_valid), 0);
    check_val("drain_count", int'(count), 0);
    check_val("drain_ready", int'(enqueue_ready), 1);

    // Duplicate suppression.
    enqueue_valid = 1'b1; enqueue_id = 2'd1;
    step();
    check_val("dup_first", int'(dup_drop), 0);
    check_val("dup_cnt1", int'(count), 1);
    step();
    check_val("dup_pulse", int'(dup_drop), 1);
    check_val("dup_cnt2", int'(count), 1);
    idle();
    step();
    check_val("dup_clear", int'(dup_drop), 0);
    check_val("dup_head", int'(current_id), 1);
    current_consume = 1'b1;
    step();
    idle();
    check_val("dup_empty", int'(count), 0);
    check_val("dup_empty_v", int'(current_valid), 0);

    // Full with simultaneous push/pop: pop happens, push refused, overflow sticks.
    for (int i = 0; i < 4; i++) begin
      enqueue_valid = 1'b1;
      enqueue_id = 2'(fill_ids[i]);
      step();
    end
    check_val("ovf_full", int'(count), 4);
    check_val("ovf_pre", int'(overflow), 0);
    enqueue_id = 2'd2; current_consume = 1'b1;
    step();
    idle();
    check_val("ovf_count", int'(count), 3);
    check_val("ovf_set", int'(overflow), 1);
    check_val("ovf_head", int'(current_id), 0);
    step();
    check_val("ovf_sticky", int'(overflow), 1);

    // Same-cycle pop and re-enqueue of the head ID.
    current_consume = 1'b1;
    step();
    check_val("re_head", int'(current_id), 3);
    enqueue_valid = 1'b1; enqueue_id = 2'd3;
    step();
    idle();
    check_val("re_count", int'(count), 2);
    check_val("re_dup", int'(dup_drop), 0);
    check_val("re_head1", int'(current_id), 1);
    current_consume = 1'b1;
    step();
    check_val("re_tail", int'(current_id), 3);
    step();
    check_val("re_empty", int'(count), 0);

    // Pop while empty is ignored.
    step();
    idle();
    check_val("emp_count", int'(count), 0);
    check_val("emp_valid", int'(current_valid), 0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      enqueue_valid = 1'b1;
      enqueue_id = 2'(i);
      step();
    end
    idle();
    check_val("pre_rst_cnt", int'(count), 3);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_count", int'(count), 0);
    check_val("arst_valid", int'(current_valid), 0);
    check_val("arst_ovf", int'(overflow), 0);
    check_val("arst_ready", int'(enqueue_ready), 1);
    step();
    reset = 1'b0;
    enqueue_valid = 1'b1; enqueue_id = 2'd1;
    step();
    idle();
    check_val("post_rst_cnt", int'(count), 1);
    check_val("post_rst_id", int'(current_id), 1);
    check_val("post_rst_dup", int'(dup_drop), 0);
`else
    // Held inputs produce exactly one event each.
    enqueue_valid = 1'b1; enqueue_id = 2'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("edge_enq_cnt", int'(count), 1);
    end
    idle();
    check_val("edge_enq_dup", int'(dup_drop), 0);
    check_val("edge_head", int'(current_id), 0);
    current_consume = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("edge_deq_cnt", int'(count), 0);
    end
    idle();
    check_val("edge_valid", int'(current_valid), 0);
    check_val("edge_ovf", int'(overflow), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_id_fifo_queue.md
Name: core_id_fifo_queue

Overview:
- Parametrised successor to the single-slot core ready queue.
- True FIFO of core IDs with configurable depth, ready/valid handshake, occupancy count, and per-core duplicate suppression.
- Sits between the core array, whose cores post "task done / idle" IDs, and the dispatcher, which consumes IDs in arrival order.

Parameters:
- CORES, 4: number of cores; ID width IDW = max(1, $clog2(CORES)).
- DEPTH, 4: FIFO entries; power of two, >= 2. Need not exceed CORES, because duplicates are suppressed.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enqueue_id  in  IDW  core ID to enqueue
- enqueue_valid  in  1  enqueue request
- enqueue_ready  out  1  FIFO can accept an entry (not full)
- current_id  out  IDW  ID at FIFO head
- current_valid  out  1  head holds a valid entry (not empty)
- current_consume  in  1  dispatcher pops the head
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- dup_drop  out  1  one-cycle pulse: enqueue dropped, ID already pending
- overflow  out  1  sticky: enqueue attempted while full

Behaviour:
- Reset is asynchronous and active-high, applied to every register. While reset is asserted:
  - wr_ptr = rd_ptr = 0, count = 0
  - pending bitmap = 0
  - dup_drop = 0, overflow = 0
  - current_valid = 0, enqueue_ready = 1
  - current_id = 0; the storage array need not be reset, but current_id is masked to 0 when empty.
- Storage: DEPTH x IDW register array. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Pending bitmap: CORES bits. Bit i is set while ID i is in the FIFO.
- Enqueue event (enq) = enqueue_valid & enqueue_ready & ~pending_eff[enqueue_id].
  - pending_eff is the pending bitmap with the bit of a same-cycle consumed head ID cleared. A core may therefore re-enqueue in the same cycle its ID is popped.
  - On enq: write mem[wr_ptr], wr_ptr+1, set pending[enqueue_id].
- Duplicate drop: enqueue_valid & enqueue_ready & pending_eff[enqueue_id] pulses dup_drop high for the next cycle. No state change.
- Overflow: enqueue_valid & ~enqueue_ready sets overflow on the next edge. It stays set until reset. The entry is lost.
- Dequeue event (deq) = current_consume & current_valid.
  - On deq: rd_ptr+1, clear pending[current_id].
  - current_consume while empty is ignored.
- Outputs:
  - enqueue_ready = (count != DEPTH).
  - current_valid = (count != 0).
  - current_id = mem[rd_ptr], combinational from registers.
- Latency: an entry accepted at edge N appears on current_* after edge N (zero-cycle bypass is not provided). A popped entry is replaced by the next head after the same edge.
- Simultaneous enq and deq:
  - count unchanged; both pointers advance.
  - Allowed when non-empty.
  - When full, enqueue_ready = 0, so the enqueue is refused even with a concurrent pop. No combinational ready-from-consume path exists.
- Count arithmetic: count + enq - deq. It never exceeds DEPTH and never underflows.
- Out-of-range enqueue_id (>= CORES when CORES is not a power of two): treated as a duplicate and dropped with dup_drop.

Optional Feature:
- Macro: CORE_QUEUE_EDGE_TRIGGER_EN.
- Defined:
  - enqueue_valid and current_consume are qualified by rising-edge detection, using registered copies (enqueue_valid_d, current_consume_d, reset to 0).
  - An enq or deq is taken only on the cycle where the input is high and its _d copy is low. A held-high input produces exactly one event.
  - overflow is likewise evaluated only on the enqueue_valid rising edge.
- Undefined: inputs are level-sensitive. Each cycle with valid/consume high is a separate event.

Test Plan:
- Reset, then enqueue IDs 2,0,3,1 on consecutive cycles -> count 1..4, enqueue_ready=0 after the 4th; pops return 2,0,3,1 in order; current_valid=0 and count=0 at the end.
- Enqueue ID 1 twice with no pop -> second attempt gives dup_drop=1 for one cycle; count stays 1; only one ID 1 is popped.
- FIFO full (DEPTH=4), enqueue_valid with ID 2 plus current_consume in the same cycle -> pop occurs, enqueue refused, overflow=1 and sticky, count=3.
- Head=ID 3; same cycle current_consume=1 and enqueue ID 3 -> accepted, no dup_drop, count unchanged, ID 3 reappears at the tail.
- current_consume pulsed while empty -> no change, count stays 0. Assert reset mid-stream with count=3 -> count=0, current_valid=0, overflow=0 immediately, without waiting for a clock edge.
- With CORE_QUEUE_EDGE_TRIGGER_EN, hold enqueue_valid high 5 cycles with ID 0, then hold current_consume high 5 cycles -> exactly one enqueue and one pop; count goes 0->1->0.
